// File: rtl/speck_key_store.sv
// speck_key_store: SPECK128/128 round-key expander and store feeding the round datapath
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   key, signal_start          master key {l0, k0}, loaded when expansion is accepted
//   busy, finished             expansion in progress / one-cycle pulse when all keys are stored
//   rd_req                     request the next stored round key (READY only)
//   rd_valid, rd_key,          one-cycle pulse with the round key, its round index and
//   rd_round, rd_last          an end-of-pass flag
module speck_key_store #(
    parameter int NR_ROUNDS = 32,
    parameter bit REVERSE   = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic         signal_start,
    output logic         busy,
    output logic         finished,
    input  logic         rd_req,
    output logic         rd_valid,
    output logic [63:0]  rd_key,
    output logic [5:0]   rd_round,
    output logic         rd_last
);
    localparam int IW = NR_ROUNDS > 1 ? $clog2(NR_ROUNDS) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(NR_ROUNDS - 1);
    localparam logic [IW-1:0] FIRST  = REVERSE ? LAST_I : '0;
    localparam logic [IW-1:0] FINAL  = REVERSE ? '0 : LAST_I;

    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t        state, state_next;
    logic [63:0]   l, k, l_new, k_new;
    logic [IW-1:0] i, ptr;
    logic [63:0]   store [NR_ROUNDS];
    logic          load, step, last, read;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;

    // A start request in READY takes priority over a read in the same cycle.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        read       = 1'b0;
        case (state)
            IDLE: begin
                load       = signal_start;
                state_next = signal_start ? EXPAND : IDLE;
            end
            EXPAND: begin
                step       = 1'b1;
                last       = i == LAST_I;
                state_next = last ? READY : EXPAND;
            end
            READY: begin
                load       = signal_start;
                read       = rd_req && !signal_start;
                state_next = signal_start ? EXPAND : READY;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy  = state == EXPAND;
    assign l_new = (k + {l[7:0], l[63:8]}) ^ 64'(i);
    assign k_new = {k[60:0], k[63:61]} ^ l_new;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            l        <= '0;
            k        <= '0;
            i        <= '0;
            ptr      <= FIRST;
            finished <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_key   <= '0;
            rd_round <= '0;
        end else begin
            finished <= last;
            rd_valid <= read;
            rd_last  <= read && ptr == FINAL;
            if (load) begin
                l   <= key[127:64];
                k   <= key[63:0];
                i   <= '0;
                ptr <= FIRST;
            end
            if (step) begin
                l <= l_new;
                k <= k_new;
                i <= i + 1'b1;
            end
            if (last)
                ptr <= FIRST;
            if (read) begin
                rd_key   <= store[ptr];
                rd_round <= 6'(ptr);
                ptr      <= ptr == FINAL ? FIRST : REVERSE ? ptr - 1'b1 : ptr + 1'b1;
            end
        end

    // The key store needs no reset: its contents only matter after a full expansion.
    always_ff @(posedge clk)
        if (step)
            store[i] <= k;
endmodule

// File: tb/tb_speck_key_store.sv
// tb_speck_key_store: directed checks of the SPECK128/128 key store in both readout orders
module tb_speck_key_store;
    localparam int NR = 32;
    localparam logic [127:0] TV   = 128'h0f0e0d0c0b0a0908_0706050403020100;
    localparam logic [127:0] KEY2 = 128'h0123456789abcdef_fedcba9876543210;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] key = '0;
    logic         signal_start = 1'b0;
    logic         rd_req = 1'b0;
    logic         busy, finished, rd_valid, rd_last;
    logic [63:0]  rd_key;
    logic [5:0]   rd_round;
    logic         busy_f, finished_f, rd_valid_f, rd_last_f;
    logic [63:0]  rd_key_f;
    logic [5:0]   rd_round_f;

    logic [63:0]  exp_keys [NR];
    logic [63:0]  got [NR];
    int           n_checks = 0;
    int           n_fail = 0;
    int           lat, bcnt, rv;

    speck_key_store #(.NR_ROUNDS(NR), .REVERSE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .key(key), .signal_start(signal_start),
        .busy(busy), .finished(finished), .rd_req(rd_req), .rd_valid(rd_valid),
        .rd_key(rd_key), .rd_round(rd_round), .rd_last(rd_last)
    );

    speck_key_store #(.NR_ROUNDS(NR), .REVERSE(1'b0)) dut_fwd (
        .clk(clk), .rst_n(rst_n), .key(key), .signal_start(signal_start),
        .busy(busy_f), .finished(finished_f), .rd_req(rd_req), .rd_valid(rd_valid_f),
        .rd_key(rd_key_f), .rd_round(rd_round_f), .rd_last(rd_last_f)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Software SPECK128/128 key schedule.
    task automatic gen(input logic [127:0] kin);
        logic [63:0] l, k;
        l = kin[127:64];
        k = kin[63:0];
        for (int r = 0; r < NR; r++) begin
            exp_keys[r] = k;
            l = (k + {l[7:0], l[63:8]}) ^ 64'(r);
            k = {k[60:0], k[63:61]} ^ l;
        end
    endtask

    // Called just after the start edge; counts edges from the start cycle until finished.
    task automatic run_expand(input bit noise, output int lat_o, output int bcnt_o, output int rv_o);
        lat_o = 1;
        bcnt_o = 0;
        rv_o = 0;
        while (!finished && lat_o < 60) begin
            bcnt_o += int'(busy);
            rv_o += int'(rd_valid);
            rd_req = noise && lat_o >= 3 && lat_o < 8;
            signal_start = noise && lat_o == 12;
            step();
            lat_o++;
        end
        rd_req = 1'b0;
        signal_start = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        chk("reset_busy", busy, 0);
        chk("reset_finished", finished, 0);
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_last", rd_last, 0);
        chk("reset_rd_key", rd_key, 0);
        chk("reset_rd_round", rd_round, 0);
        rst_n = 1'b1;
        rd_req = 1'b1;
        step();
        step();
        chk("idle_rd_valid", rd_valid, 0);
        chk("idle_busy", busy, 0);
        rd_req = 1'b0;

        gen(TV);
        key = TV;
        signal_start = 1'b1;
        step();
        signal_start = 1'b0;
        chk("start_busy", busy, 1);
        run_expand(1'b1, lat, bcnt, rv);
        chk("tv_latency", lat, 33);
        chk("tv_busy_cycles", bcnt, 32);
        chk("expand_rd_valid", rv, 0);
        chk("tv_finished", finished, 1);
        chk("tv_busy_done", busy, 0);
        chk("tv_fwd_finished", finished_f, 1);
        step();
        chk("finished_pulse", finished, 0);

        rd_req = 1'b1;
        for (int j = 0; j < NR; j++) begin
            step();
            if (j == NR - 1) rd_req = 1'b0;
            got[NR - 1 - j] = rd_key;
            chk("rev_valid", rd_valid, 1);
            chk("rev_round", rd_round, 64'(NR - 1 - j));
            chk("rev_key", rd_key, exp_keys[NR - 1 - j]);
            chk("rev_last", rd_last, 64'(j == NR - 1));
            chk("fwd_round", rd_round_f, 64'(j));
            chk("fwd_key", rd_key_f, exp_keys[j]);
            chk("fwd_last", rd_last_f, 64'(j == NR - 1));
        end
        chk("tv_round1_key", got[1], 64'h37253b31171d0309);
        chk("tv_round0_key", got[0], 64'h0706050403020100);
        step();
        chk("idle_gap_valid", rd_valid, 0);
        chk("hold_key", rd_key, 64'h0706050403020100);
        chk("hold_round", rd_round, 0);
        chk("gap_last", rd_last, 0);

        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("wrap_valid", rd_valid, 1);
        chk("wrap_round", rd_round, 31);
        chk("wrap_key", rd_key, exp_keys[31]);
        chk("wrap_last", rd_last, 0);

        rd_req = 1'b1;
        repeat (10) step();
        chk("pre_collision_round", rd_round, 21);
        key = KEY2;
        signal_start = 1'b1;
        step();
        signal_start = 1'b0;
        rd_req = 1'b0;
        chk("collision_valid", rd_valid, 0);
        chk("collision_busy", busy, 1);
        run_expand(1'b0, lat, bcnt, rv);
        chk("collision_latency", lat, 33);
        chk("collision_rv", rv, 0);
        gen(KEY2);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("collision_round", rd_round, 31);
        chk("collision_key", rd_key, exp_keys[31]);

        key = TV;
        signal_start = 1'b1;
        step();
        signal_start = 1'b0;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_finished", finished, 0);
        chk("async_rd_round", rd_round, 0);
        step();
        step();
        rst_n = 1'b1;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        chk("post_reset_idle_valid", rd_valid, 0);
        chk("post_reset_idle_busy", busy, 0);
        gen(TV);
        signal_start = 1'b1;
        step();
        signal_start = 1'b0;
        run_expand(1'b0, lat, bcnt, rv);
        chk("rerun_latency", lat, 33);
        chk("rerun_busy_cycles", bcnt, 32);
        rd_req = 1'b1;
        step();
        chk("rerun_round31", rd_round, 31);
        chk("rerun_key31", rd_key, exp_keys[31]);
        chk("rerun_fwd_key0", rd_key_f, 64'h0706050403020100);
        step();
        rd_req = 1'b0;
        chk("rerun_round30", rd_round, 30);
        chk("rerun_key30", rd_key, exp_keys[30]);
        chk("rerun_fwd_key1", rd_key_f, 64'h37253b31171d0309);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
